// File: rtl/osc_acq_pkg.sv
// Shared types and the trigger edge compare for the acquisition path.
package osc_acq_pkg;

    // Wide enough for any calibrated sample width used on this board.
    localparam int EDGE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRETRIG  = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POSTTRIG = 3'd3,
        ST_READY    = 3'd4
    } acq_state_t;

    typedef enum logic [1:0] {
        AUTO    = 2'd0,
        NORMAL  = 2'd1,
        SINGLE  = 2'd2,
        FREERUN = 2'd3
    } trig_mode_t;

    // Rising: crossing up to/over level. Falling: crossing down to/under level.
    function automatic logic edge_hit(input logic [EDGE_W-1:0] prev,
                                      input logic [EDGE_W-1:0] cur,
                                      input logic [EDGE_W-1:0] level,
                                      input logic              slope);
        if (slope)
            return (prev > level) && (cur <= level);
        else
            return (prev < level) && (cur >= level);
    endfunction

endpackage

// File: rtl/trig_edge_detect.sv
// Previous-sample register and edge compare; hit is combinational and
// aligned with the sample_tick that completes the crossing.
module trig_edge_detect
    import osc_acq_pkg::*;
#(
    parameter int DSIZE = 10
) (
    input  logic             CLK100MHz,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             sample_tick,
    input  logic [DSIZE-1:0] sample,
    input  logic [DSIZE-1:0] trig_level,
    input  logic             trig_slope,
    output logic             hit
);

    logic [DSIZE-1:0] prev;
    logic             prev_vld;

    // Track the last accepted sample; a fresh arm invalidates it so the
    // first tick of a frame only loads the history.
    always_ff @(posedge CLK100MHz or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            prev_vld <= 1'b0;
        end else if (clr) begin
            prev_vld <= 1'b0;
        end else if (en && sample_tick) begin
            prev     <= sample;
            prev_vld <= 1'b1;
        end
    end

    assign hit = en && sample_tick && prev_vld &&
                 edge_hit(EDGE_W'(prev), EDGE_W'(sample), EDGE_W'(trig_level), trig_slope);

endmodule

// File: rtl/acq_trigger_ctrl.sv
// Capture sequencer for one channel: arm, pre-fill, trigger, post-fill and
// frame handoff to the readout side over a ready/ack handshake.
module acq_trigger_ctrl
    import osc_acq_pkg::*;
#(
    parameter int DSIZE        = 10,
    parameter int ASIZE        = 9,
    parameter int AUTO_TIMEOUT = 2_000_000
) (
    input  logic             CLK100MHz,
    input  logic             rst_n,
    input  logic             sample_tick,
    input  logic [DSIZE-1:0] sample,
    input  logic [DSIZE-1:0] trig_level,
    input  logic             trig_slope,
    input  logic [1:0]       trig_mode,
    input  logic [ASIZE-1:0] pre_count,
    input  logic             arm,
    input  logic             abort,
    output logic             wr_en,
    output logic [ASIZE-1:0] wr_addr,
    output logic [DSIZE-1:0] wr_data,
    output logic [ASIZE-1:0] trig_addr,
    output logic [ASIZE-1:0] rd_start,
    output logic             frame_ready,
    input  logic             frame_ack,
    output logic             triggered_auto,
    output logic [2:0]       state_o
);

    localparam int               CW       = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [CW-1:0]    TO_LAST  = CW'(AUTO_TIMEOUT - 1);
    localparam logic [ASIZE-1:0] ADDR_MAX = '1;
    localparam logic [ASIZE-1:0] A_ONE    = ASIZE'(1);

    acq_state_t       state;
    trig_mode_t       mode_lat;
    logic [ASIZE-1:0] pre_lat, pre_cnt, post_cnt, wr_ptr;
    logic [CW-1:0]    to_cnt;
    logic             force_trig;
    logic             active, rearm, edge_now, auto_fire, trig_now;

    assign active    = (state == ST_PRETRIG) || (state == ST_ARMED) || (state == ST_POSTTRIG);
    // A new frame starts from IDLE on arm, or from READY on ack (re-arm).
    assign rearm     = ((state == ST_IDLE) && arm) || ((state == ST_READY) && frame_ack);
    assign auto_fire = (mode_lat == AUTO) && force_trig;
    assign trig_now  = sample_tick && (state == ST_ARMED) &&
                       ((mode_lat == FREERUN) || edge_now || auto_fire);
    assign state_o   = state;

    trig_edge_detect #(.DSIZE(DSIZE)) u_edge (
        .CLK100MHz   (CLK100MHz),
        .rst_n       (rst_n),
        .clr         (rearm),
        .en          (active),
        .sample_tick (sample_tick),
        .sample      (sample),
        .trig_level  (trig_level),
        .trig_slope  (trig_slope),
        .hit         (edge_now)
    );

    // Sequencer FSM with registered RAM write port and frame status.
    always_ff @(posedge CLK100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            mode_lat       <= AUTO;
            pre_lat        <= '0;
            pre_cnt        <= '0;
            post_cnt       <= '0;
            wr_ptr         <= '0;
            to_cnt         <= '0;
            force_trig     <= 1'b0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            trig_addr      <= '0;
            rd_start       <= '0;
            frame_ready    <= 1'b0;
            triggered_auto <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (abort) begin
                state       <= ST_IDLE;
                frame_ready <= 1'b0;
            end else begin
                // Write pointer keeps running circularly across frames.
                if (active && sample_tick) begin
                    wr_en   <= 1'b1;
                    wr_addr <= wr_ptr;
                    wr_data <= sample;
                    wr_ptr  <= wr_ptr + A_ONE;
                end
                case (state)
                    ST_IDLE: begin
                        if (arm) begin
                            // pre_count is ASIZE wide, so it never exceeds 2^ASIZE-1.
                            pre_lat    <= pre_count;
                            mode_lat   <= trig_mode_t'(trig_mode);
                            pre_cnt    <= '0;
                            post_cnt   <= '0;
                            to_cnt     <= '0;
                            force_trig <= 1'b0;
                            state      <= (pre_count == '0) ? ST_ARMED : ST_PRETRIG;
                        end
                    end
                    ST_PRETRIG: begin
                        if (sample_tick) begin
                            pre_cnt <= pre_cnt + A_ONE;
                            if (pre_cnt == pre_lat - A_ONE)
                                state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (trig_now) begin
                            trig_addr      <= wr_ptr;
                            rd_start       <= wr_ptr - pre_lat;
                            triggered_auto <= auto_fire && !edge_now;
                            post_cnt       <= ADDR_MAX - pre_lat;
                            state          <= (pre_lat == ADDR_MAX) ? ST_READY : ST_POSTTRIG;
                        end else if (!force_trig) begin
                            if (to_cnt == TO_LAST)
                                force_trig <= 1'b1;
                            else
                                to_cnt <= to_cnt + CW'(1);
                        end
                    end
                    ST_POSTTRIG: begin
                        if (sample_tick) begin
                            post_cnt <= post_cnt - A_ONE;
                            if (post_cnt == A_ONE)
                                state <= ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (frame_ack) begin
                            frame_ready <= 1'b0;
                            pre_cnt     <= '0;
                            to_cnt      <= '0;
                            force_trig  <= 1'b0;
                            if (mode_lat == SINGLE)
                                state <= ST_IDLE;
                            else
                                state <= (pre_lat == '0) ? ST_ARMED : ST_PRETRIG;
                        end else begin
                            frame_ready <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// Randomized bench for acq_trigger_ctrl with a tick-index reference model.
module tb_acq_trigger_ctrl;

    localparam int DSIZE = 10;
    localparam int ASIZE = 9;
    localparam int TO    = 1000;
    localparam int DEPTH = 1 << ASIZE;
    localparam int AMAX  = DEPTH - 1;

    logic             CLK100MHz = 1'b0;
    logic             rst_n;
    logic             sample_tick, trig_slope, arm, abort, frame_ack;
    logic [DSIZE-1:0] sample, trig_level;
    logic [1:0]       trig_mode;
    logic [ASIZE-1:0] pre_count;
    logic             wr_en, frame_ready, triggered_auto;
    logic [ASIZE-1:0] wr_addr, trig_addr, rd_start;
    logic [DSIZE-1:0] wr_data;
    logic [2:0]       state_o;

    acq_trigger_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AUTO_TIMEOUT(TO)) dut (
        .CLK100MHz(CLK100MHz), .rst_n(rst_n), .sample_tick(sample_tick), .sample(sample),
        .trig_level(trig_level), .trig_slope(trig_slope), .trig_mode(trig_mode),
        .pre_count(pre_count), .arm(arm), .abort(abort), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .trig_addr(trig_addr), .rd_start(rd_start),
        .frame_ready(frame_ready), .frame_ack(frame_ack), .triggered_auto(triggered_auto),
        .state_o(state_o)
    );

    initial forever #5 CLK100MHz = ~CLK100MHz;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int wq_addr[$], wq_data[$], wq_cyc[$];
    int fr_rise = -1;
    logic fr_q = 1'b0;
    int smp[$], gap[$];
    int g_mode, g_pre, g_lvl, g_slope;
    int exp_ptr = 0;
    int ack_slot = 0;

    always @(posedge CLK100MHz) cyc++;

    // Record every RAM write and the frame_ready rising edge.
    always @(negedge CLK100MHz) begin
        if (wr_en === 1'b1) begin
            wq_addr.push_back(int'(wr_addr));
            wq_data.push_back(int'(wr_data));
            wq_cyc.push_back(cyc);
        end
        if (frame_ready === 1'b1 && fr_q !== 1'b1) fr_rise = cyc;
        fr_q = frame_ready;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic bit mdl_edge(input int p, input int s);
        if (g_slope != 0) return (p > g_lvl) && (s <= g_lvl);
        else              return (p < g_lvl) && (s >= g_lvl);
    endfunction

    task automatic step();
        @(posedge CLK100MHz); #1;
        sample_tick = 0; arm = 0; abort = 0; frame_ack = 0;
    endtask

    // kind: 0 ramp, 1 constant 100, 2 sine, 3 uniform random
    task automatic mk_plan(input int n, input int kind, input int maxgap);
        real ph;
        int v;
        ph = $urandom_range(0, 62) / 10.0;
        smp.delete(); gap.delete();
        for (int k = 0; k < n; k++) begin
            case (kind)
                0:       v = k % 1024;
                1:       v = 100;
                2:       v = 500 + $rtoi(400.0 * $sin(ph + 6.2831853 * k / 50.0));
                default: v = int'($urandom_range(0, 1023));
            endcase
            smp.push_back(v);
            gap.push_back(int'($urandom_range(0, maxgap)));
        end
    endtask

    task automatic run_frame(input string nm, input bit do_arm, input bit plant, input int abort_at);
        int c[$];
        int a, t, e_arm, kstar, L, nd, nexp, bad;
        bit h, fa, exp_auto;
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); fr_rise = -1;
        if (do_arm) begin
            step();
            arm = 1; trig_mode = 2'(g_mode); pre_count = ASIZE'(g_pre);
            trig_level = DSIZE'(g_lvl); trig_slope = g_slope[0];
            a = cyc;
        end else a = ack_slot;
        t = cyc;
        foreach (gap[k]) begin t += gap[k] + 1; c.push_back(t); end
        // Reference: trigger = first tick at/after the pre-fill that is an
        // edge, free-run, or lands once the auto timeout has elapsed.
        e_arm = (g_pre == 0) ? a + 1 : c[g_pre - 1] + 1;
        kstar = -1; exp_auto = 0;
        for (int k = g_pre; k < smp.size() && kstar < 0; k++) begin
            fa = (g_mode == 0) && (c[k] >= e_arm + TO);
            if (plant && fa) smp[k] = 600;
            h = (k > 0) && mdl_edge(smp[k - 1], smp[k]);
            if (h || fa || g_mode == 3) begin kstar = k; exp_auto = fa && !h; end
        end
        L = kstar + (AMAX - g_pre);
        chk({nm, "_plan_ok"}, (kstar >= 0 && L + 5 <= smp.size()) ? 1 : 0, 1);
        if (kstar < 0 || L + 5 > smp.size()) return;
        nd = (abort_at >= 0) ? kstar + abort_at : L + 4;
        for (int k = 0; k <= nd; k++) begin
            repeat (gap[k]) step();
            step();
            sample_tick = 1; sample = DSIZE'(smp[k]);
            if (abort_at >= 0 && k == nd) begin abort = 1; frame_ack = 1; arm = 1; end
        end
        step();
        @(negedge CLK100MHz);
        if (abort_at >= 0) begin
            chk({nm, "_abort_wr_en"}, wr_en, 0);
            chk({nm, "_abort_state"}, state_o, 0);
            chk({nm, "_abort_ready"}, frame_ready, 0);
            for (int k = 0; k < 6; k++) begin step(); sample_tick = 1; sample = DSIZE'(k); end
            step();
            @(negedge CLK100MHz);
            chk({nm, "_abort_ready_hold"}, frame_ready, 0);
            nexp = nd;
        end else nexp = L + 1;
        chk({nm, "_nwrites"}, wq_addr.size(), nexp);
        bad = -1;
        for (int k = 0; k < wq_addr.size() && k < nexp; k++)
            if (bad < 0 && (wq_addr[k] != (exp_ptr + k) % DEPTH || wq_data[k] != smp[k])) bad = k;
        if (bad < 0) bad = 0;
        if (wq_addr.size() > bad) begin
            chk({nm, "_wr_addr"}, wq_addr[bad], (exp_ptr + bad) % DEPTH);
            chk({nm, "_wr_data"}, wq_data[bad], smp[bad]);
        end
        if (abort_at < 0) begin
            chk({nm, "_trig_addr"}, trig_addr, (exp_ptr + kstar) % DEPTH);
            chk({nm, "_rd_start"}, rd_start, (exp_ptr + kstar - g_pre + DEPTH) % DEPTH);
            chk({nm, "_trig_auto"}, triggered_auto, exp_auto);
            chk({nm, "_frame_ready"}, frame_ready, 1);
            chk({nm, "_state_ready"}, state_o, 4);
            if (wq_cyc.size() == nexp) chk({nm, "_ready_lat"}, fr_rise - wq_cyc[nexp - 1], 1);
        end
        exp_ptr = (exp_ptr + nexp) % DEPTH;
    endtask

    task automatic do_ack(input string nm, input int exp_state);
        step(); frame_ack = 1; ack_slot = cyc;
        step();
        @(negedge CLK100MHz);
        chk({nm, "_ack_ready"}, frame_ready, 0);
        chk({nm, "_ack_state"}, state_o, exp_state);
    endtask

    task automatic do_abort(input string nm);
        step(); abort = 1;
        step();
        @(negedge CLK100MHz);
        chk({nm, "_idle"}, state_o, 0);
    endtask

    initial begin
        int pres[3];
        int nst;
        rst_n = 0; sample_tick = 0; sample = '0; trig_level = '0; trig_slope = 0;
        trig_mode = '0; pre_count = '0; arm = 0; abort = 0; frame_ack = 0;
        #12;
        chk("reset_outs", {wr_en, wr_addr, wr_data, trig_addr, rd_start, frame_ready, triggered_auto, state_o}, 0);
        #10 rst_n = 1;

        // Ramp through a rising threshold, then re-armed random frame with wrap.
        g_mode = 1; g_pre = 256; g_lvl = 500; g_slope = 0;
        mk_plan(1024, 0, 2);
        run_frame("ramp", 1, 0, -1);
        do_ack("ramp", 1);
        mk_plan(1100, 3, 1);
        run_frame("rearm", 0, 0, -1);
        do_ack("rearm", 1);
        mk_plan(1100, 3, 1);
        run_frame("abort", 0, 0, 10);

        // Auto timeout on a flat signal, then an edge on the timeout tick.
        g_mode = 0; g_pre = 20; g_lvl = 500; g_slope = 0;
        mk_plan(1600, 1, 2);
        run_frame("auto", 1, 0, -1);
        do_ack("auto", 1);
        mk_plan(1600, 1, 2);
        run_frame("auto_edge", 0, 1, -1);
        do_ack("auto_edge", 1);
        do_abort("auto_stop");

        // Falling sine, no pre-trigger, single shot.
        g_mode = 2; g_pre = 0; g_lvl = 300; g_slope = 1;
        mk_plan(700, 2, 1);
        run_frame("fall", 1, 0, -1);
        do_ack("fall", 0);
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        for (int k = 0; k < 10; k++) begin step(); sample_tick = 1; sample = DSIZE'(k * 90); end
        step();
        @(negedge CLK100MHz);
        chk("single_idle_nwr", wq_addr.size(), 0);
        chk("single_idle_state", state_o, 0);

        // Random frames covering full pre-fill and zero pre-fill.
        pres[0] = AMAX; pres[1] = 0; pres[2] = int'($urandom_range(1, AMAX - 1));
        for (int i = 0; i < 3; i++) begin
            g_mode = int'($urandom_range(1, 3)); g_pre = pres[i];
            g_lvl = int'($urandom_range(200, 800)); g_slope = int'($urandom_range(0, 1));
            mk_plan(1100, 3, 1);
            run_frame($sformatf("rnd%0d", i), 1, 0, -1);
            nst = (g_mode == 2) ? 0 : ((g_pre == 0) ? 2 : 1);
            do_ack($sformatf("rnd%0d", i), nst);
            if (g_mode != 2) do_abort($sformatf("rnd%0d_stop", i));
        end

        // Asynchronous reset while waiting in ARMED.
        g_mode = 1; g_pre = 10; g_lvl = 1023; g_slope = 0;
        step();
        arm = 1; trig_mode = 2'(g_mode); pre_count = ASIZE'(g_pre);
        trig_level = DSIZE'(g_lvl); trig_slope = 0;
        for (int k = 0; k < 40; k++) begin step(); sample_tick = 1; sample = DSIZE'($urandom_range(0, 999)); end
        step();
        @(negedge CLK100MHz);
        chk("armed_before_rst", state_o, 2);
        #2 rst_n = 0;
        #1;
        chk("async_rst_outs", {wr_en, wr_addr, wr_data, trig_addr, rd_start, frame_ready, triggered_auto, state_o}, 0);
        chk("async_rst_state", state_o, 0);
        #10 rst_n = 1;
        exp_ptr = 0;

        g_mode = 3; g_pre = 100; g_lvl = 0; g_slope = 0;
        mk_plan(600, 3, 1);
        run_frame("post_rst_free", 1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
